// File: rtl/iter_muldiv.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit for the execute stage.
// One ripple-carry adder is time-shared over 32 iterations per operation.

module rca #(
   parameter int W = 32
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         sub_en,
   output logic [W-1:0] sum,
   output logic         cout
);
   logic [W:0]   c;
   logic [W-1:0] yy;

   always_comb begin
      yy   = y ^ {W{sub_en}};
      c    = '0;
      sum  = '0;
      c[0] = sub_en;
      for (int i = 0; i < W; i++) begin
         sum[i]   = x[i] ^ yy[i] ^ c[i];
         c[i+1]   = (x[i] & yy[i]) | (c[i] & (x[i] ^ yy[i]));
      end
      cout = c[W];
   end
endmodule

module iter_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [4:0]      cnt_q, cnt_d;

   logic            is_div;
   logic [XLEN-1:0] rs;
   logic [XLEN-1:0] rca_x;
   logic [XLEN-1:0] rca_y;
   logic [XLEN-1:0] rca_s;
   logic            rca_co;
   logic            ok;

   // hi is acc (multiply) or rem (divide); lo is mpl or q.
   always_comb begin
      is_div = op_q[1];
      rs     = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
      rca_x  = is_div ? rs : hi_q;
      rca_y  = is_div ? b_q : (lo_q[0] ? a_q : '0);
      ok     = hi_q[XLEN-1] | rca_co;
   end

   rca #(.W(XLEN)) u_rca (
      .x      (rca_x),
      .y      (rca_y),
      .sub_en (is_div),
      .sum    (rca_s),
      .cout   (rca_co)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d    = op;
               a_d     = a;
               b_d     = b;
               hi_d    = '0;
               lo_d    = op[1] ? a : b;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (is_div) begin
               hi_d = ok ? rca_s : rs;
               lo_d = {lo_q[XLEN-2:0], ok};
            end else begin
               hi_d = {rca_co, rca_s[XLEN-1:1]};
               lo_d = {rca_s[0], lo_q[XLEN-1:1]};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
      end
   end

   // MULHU/REMU live in hi, MUL/DIVU in lo.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      result    = op_q[0] ? hi_q : lo_q;
   end
endmodule
